muldiv_unit: RTL and testbench

//  Iterative multiply/divide execute unit; sits directly downstream of the instruction decoder.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: decoder op codes,
// control FSM encoding and iteration-counter sizing.
package muldiv_pkg;

    localparam logic [3:0] ALU_MUL   = 4'b0100;
    localparam logic [3:0] ALU_UMULL = 4'b0110;
    localparam logic [3:0] ALU_SMULL = 4'b1000;
    localparam logic [3:0] ALU_DIV   = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    function automatic logic op_supported(input logic [3:0] code);
        return code inside {ALU_MUL, ALU_UMULL, ALU_SMULL, ALU_DIV};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract for divide.
// Purely combinational; the caller owns the accumulator/low-word registers.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        sum     = acc_in + (lo_in[0] ? {1'b0, operand} : '0);
        shifted = {acc_in[WIDTH-1:0], lo_in[WIDTH-1]};
        ge      = (shifted >= {1'b0, operand});
        diff    = shifted - {1'b0, operand};
        if (is_div) begin
            acc_out = ge ? diff : shifted;
            lo_out  = {lo_in[WIDTH-2:0], ge};
        end else begin
            // The carry out of the add lands in the top product bit after the shift.
            acc_out = {1'b0, sum[WIDTH:1]};
            lo_out  = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/UMULL/SMULL/DIV execute unit with a start/busy/done handshake.
// Control FSM, operand/result registers and the signed-product fix-up live here.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       Flags,
    output logic             DivZero
);

    localparam int CW = cnt_width(WIDTH);

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [1:0]         flags_q, flags_d;
    logic               dz_q, dz_d;

    logic               op_ok;
    logic               div_by_zero;
    logic               is_div;
    logic [WIDTH:0]     acc_step;
    logic [WIDTH-1:0]   lo_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   fix_hi;
    logic [1:0]         fix_flags;

    assign op_ok       = op_supported(op);
    assign div_by_zero = (op == ALU_DIV) && (SrcB == '0);
    assign is_div      = (op_q == ALU_DIV);

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div (is_div),
        .acc_in (acc_q),
        .lo_in  (lo_q),
        .operand(opnd_q),
        .acc_out(acc_step),
        .lo_out (lo_step)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (div_by_zero || !op_ok) ? DONE : CALC;
            CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == CALC) || (state_q == FIX);
        done    = (state_q == DONE);
        DivZero = (state_q == DONE) && dz_q;
    end

    assign ResultLo = res_lo_q;
    assign ResultHi = res_hi_q;
    assign Flags    = flags_q;

    // Final result formatting: sign fix for SMULL, Hi/flag selection per op.
    always_comb begin
        prod = {acc_q[WIDTH-1:0], lo_q};
        if ((op_q == ALU_SMULL) && neg_q) prod = -prod;
        fix_lo    = prod[WIDTH-1:0];
        fix_hi    = prod[2*WIDTH-1:WIDTH];
        fix_flags = {fix_hi[WIDTH-1], prod == '0};
        case (op_q)
            ALU_MUL: begin
                fix_hi    = '0;
                fix_flags = {fix_lo[WIDTH-1], fix_lo == '0};
            end
            ALU_DIV: begin
                fix_lo    = lo_q;
                fix_hi    = acc_q[WIDTH-1:0];
                fix_flags = {lo_q[WIDTH-1], lo_q == '0};
            end
            default: ;
        endcase
    end

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op;
                    dz_d = 1'b0;
                    if (div_by_zero) begin
                        res_lo_d = '0;
                        res_hi_d = SrcA;
                        flags_d  = 2'b01;
                        dz_d     = 1'b1;
                    end else if (!op_ok) begin
                        res_lo_d = '0;
                        res_hi_d = '0;
                        flags_d  = 2'b01;
                    end else begin
                        acc_d = '0;
                        cnt_d = '0;
                        if (op == ALU_SMULL) begin
                            lo_d   = abs_val(SrcA);
                            opnd_d = abs_val(SrcB);
                            neg_d  = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
                        end else begin
                            lo_d   = SrcA;
                            opnd_d = SrcB;
                            neg_d  = 1'b0;
                        end
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                lo_d  = lo_step;
                cnt_d = cnt_q + CW'(1);
            end
            FIX: begin
                res_lo_d = fix_lo;
                res_hi_d = fix_hi;
                flags_d  = fix_flags;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            dz_q     <= 1'b0;
        end else begin
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
            dz_q     <= dz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, flags, latency,
// divide-by-zero, start filtering, mid-operation reset and back-to-back ops.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  fl;
        logic        dz;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] ResultLo;
    logic [31:0] ResultHi;
    logic [1:0]  Flags;
    logic        DivZero;

    int tests_run    = 0;
    int tests_failed = 0;
    bit overlap_seen = 1'b0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .busy    (busy),
        .done    (done),
        .ResultLo(ResultLo),
        .ResultHi(ResultHi),
        .Flags   (Flags),
        .DivZero (DivZero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap_seen = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Moves into a fresh cycle, issues one start, returns at the done cycle (lat=-1 on timeout).
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [66:0] res);
        @(posedge clk); #1;
        start = 1'b1; op = o; SrcA = a; SrcB = b;
        lat = -1;
        res = '0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (done) begin
                lat = n;
                res = {ResultHi, ResultLo, Flags, DivZero};
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = '0; SrcA = '0; SrcB = '0;
        #2;
        if ({busy, done, ResultHi, ResultLo, Flags, DivZero} !== '0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b hi=%h lo=%h flags=%b dz=%b required all zero",
                     busy, done, ResultHi, ResultLo, Flags, DivZero);
            tests_failed++;
        end
        tests_run++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        if ({busy, done} !== 2'b00) begin
            $display("FAIL reset_idle: got busy=%b done=%b required 0 0", busy, done);
            tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_multiply();
        vec_t        v[5];
        int          lat;
        logic [66:0] res;
        logic [66:0] exp;
        v[0] = '{ALU_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 2'b10, 1'b0};
        v[1] = '{ALU_SMULL, 32'hFFFFFFFE, 32'h00000003, 34, 32'hFFFFFFFF, 32'hFFFFFFFA, 2'b10, 1'b0};
        v[2] = '{ALU_SMULL, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h00000000, 2'b00, 1'b0};
        v[3] = '{ALU_MUL,   32'h00010000, 32'h00010000, 34, 32'h00000000, 32'h00000000, 2'b01, 1'b0};
        v[4] = '{ALU_MUL,   32'hFFFFFFFF, 32'h00000002, 34, 32'h00000000, 32'hFFFFFFFE, 2'b10, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, res);
            exp = {v[i].hi, v[i].lo, v[i].fl, v[i].dz};
            if (lat !== v[i].lat) begin
                $display("FAIL mul_latency[%0d]: got %0d cycles required %0d", i, lat, v[i].lat);
                tests_failed++;
            end
            tests_run++;
            if (res !== exp) begin
                $display("FAIL mul_result[%0d]: got {hi,lo,flags,dz}=%h required %h", i, res, exp);
                tests_failed++;
            end
            tests_run++;
        end
    endtask

    task automatic test_divide();
        vec_t        v[4];
        int          lat;
        logic [66:0] res;
        logic [66:0] exp;
        v[0] = '{ALU_DIV, 32'd100,       32'd7,       34, 32'd2,        32'd14,       2'b00, 1'b0};
        v[1] = '{ALU_DIV, 32'hFFFFFFFF,  32'd1,       34, 32'd0,        32'hFFFFFFFF, 2'b10, 1'b0};
        v[2] = '{ALU_DIV, 32'd5,         32'd0,       1,  32'd5,        32'd0,        2'b01, 1'b1};
        v[3] = '{4'b0000, 32'h00001234,  32'd5,       1,  32'd0,        32'd0,        2'b01, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, res);
            exp = {v[i].hi, v[i].lo, v[i].fl, v[i].dz};
            if (lat !== v[i].lat) begin
                $display("FAIL div_latency[%0d]: got %0d cycles required %0d", i, lat, v[i].lat);
                tests_failed++;
            end
            tests_run++;
            if (res !== exp) begin
                $display("FAIL div_result[%0d]: got {hi,lo,flags,dz}=%h required %h", i, res, exp);
                tests_failed++;
            end
            tests_run++;
        end
    endtask

    task automatic test_start_during_calc();
        int          dones = 0;
        int          first = -1;
        logic [31:0] lo    = '0;
        @(posedge clk); #1;
        start = 1'b1; op = ALU_UMULL; SrcA = 32'd2; SrcB = 32'd3;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (n == 10) begin start = 1'b1; op = ALU_DIV; SrcB = 32'd0; end
            if (n == 11) start = 1'b0;
            if (done) begin
                dones++;
                if (first < 0) begin first = n; lo = ResultLo; end
            end
        end
        if (dones !== 1) begin
            $display("FAIL ignore_start_count: got %0d done pulses required 1", dones);
            tests_failed++;
        end
        tests_run++;
        if (first !== 34) begin
            $display("FAIL ignore_start_latency: got %0d cycles required 34", first);
            tests_failed++;
        end
        tests_run++;
        if (lo !== 32'd6) begin
            $display("FAIL ignore_start_result: got lo=%h required 00000006", lo);
            tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_reset_mid_op();
        int          dones = 0;
        int          lat;
        logic [66:0] res;
        @(posedge clk); #1;
        start = 1'b1; op = ALU_UMULL; SrcA = 32'hFFFFFFFF; SrcB = 32'd2;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
        end
        if (busy !== 1'b1) begin
            $display("FAIL abort_busy_before: got busy=%b required 1", busy);
            tests_failed++;
        end
        tests_run++;
        reset = 1'b0;
        #1;
        if ({busy, done, ResultHi, ResultLo, Flags, DivZero} !== '0) begin
            $display("FAIL abort_outputs: got busy=%b done=%b hi=%h lo=%h flags=%b dz=%b required all zero",
                     busy, done, ResultHi, ResultLo, Flags, DivZero);
            tests_failed++;
        end
        tests_run++;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        if (dones !== 0) begin
            $display("FAIL abort_no_done: got %0d done pulses required 0", dones);
            tests_failed++;
        end
        tests_run++;
        run_op(ALU_UMULL, 32'd3, 32'd4, lat, res);
        if (lat !== 34 || res !== {32'd0, 32'd12, 2'b00, 1'b0}) begin
            $display("FAIL abort_recover: got lat=%0d {hi,lo,flags,dz}=%h required lat=34 %h",
                     lat, res, {32'd0, 32'd12, 2'b00, 1'b0});
            tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_back_to_back();
        int          d1 = -1;
        int          d2 = -1;
        logic [31:0] r1 = '0;
        logic [31:0] r2 = '0;
        bit          hold_bad = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = ALU_UMULL; SrcA = 32'h10; SrcB = 32'h10;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk); #1;
            if (n == 2) begin SrcA = 32'd7; SrcB = 32'd6; end
            if (done) begin
                if (d1 < 0) begin
                    d1 = n; r1 = ResultLo;
                end else begin
                    d2 = n; r2 = ResultLo;
                    start = 1'b0;
                    break;
                end
            end else if (d1 >= 0 && (ResultLo !== 32'h100 || ResultHi !== 32'h0)) begin
                hold_bad = 1'b1;
            end
        end
        start = 1'b0;
        if (d1 !== 34 || r1 !== 32'h100) begin
            $display("FAIL b2b_first: got done at %0d lo=%h required 34 00000100", d1, r1);
            tests_failed++;
        end
        tests_run++;
        if (d2 - d1 !== 35) begin
            $display("FAIL b2b_spacing: got %0d cycles between done pulses required 35", d2 - d1);
            tests_failed++;
        end
        tests_run++;
        if (r2 !== 32'd42) begin
            $display("FAIL b2b_second: got lo=%h required 0000002a", r2);
            tests_failed++;
        end
        tests_run++;
        if (hold_bad !== 1'b0) begin
            $display("FAIL b2b_hold: got results changing between ops=%b required 0", hold_bad);
            tests_failed++;
        end
        tests_run++;
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_start_during_calc();
        test_reset_mid_op();
        test_back_to_back();
        if (overlap_seen !== 1'b0) begin
            $display("FAIL busy_done_overlap: got overlap=%b required 0", overlap_seen);
            tests_failed++;
        end
        tests_run++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
